// File: rtl/haxball_pkg.sv
// Shared definitions for the match controller: FSM states, winner codes,
// parameter defaults and a saturating score increment.
package haxball_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_KICKOFF = 3'd1,
        ST_PLAY    = 3'd2,
        ST_GOAL    = 3'd3,
        ST_OVER    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2
    } winner_t;

    localparam int DEF_KICKOFF_FRAMES   = 60;
    localparam int DEF_GOAL_HOLD_FRAMES = 120;
    localparam int DEF_WIN_SCORE        = 5;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous vertical sync into the Clk domain and emits a
// single-cycle pulse on each of its rising edges.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic frame_tick
);

    logic sync1, sync2, sync2_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= frame_clk;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign frame_tick = sync2 & ~sync2_d;

endmodule

// File: rtl/match_controller.sv
// Game-flow FSM: kickoff countdown, live play, goal freeze and game over,
// with saturating scores and registered field-control outputs.
module match_controller
    import haxball_pkg::*;
#(
    parameter int KICKOFF_FRAMES   = DEF_KICKOFF_FRAMES,
    parameter int GOAL_HOLD_FRAMES = DEF_GOAL_HOLD_FRAMES,
    parameter int WIN_SCORE        = DEF_WIN_SCORE
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       start,
    input  logic       goal1,
    input  logic       goal2,
    output logic       center_field,
    output logic       freeze,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner,
    output logic [2:0] state_o
);

    if ((KICKOFF_FRAMES < 1) || (KICKOFF_FRAMES > 255) ||
        (GOAL_HOLD_FRAMES < 1) || (GOAL_HOLD_FRAMES > 255) ||
        (WIN_SCORE < 1) || (WIN_SCORE > 15)) begin : g_param_check
        $error("match_controller: frame counts must be 1..255 and WIN_SCORE 1..15");
    end

    localparam logic [7:0] KO_LIM = 8'(KICKOFF_FRAMES);
    localparam logic [7:0] GH_LIM = 8'(GOAL_HOLD_FRAMES);
    localparam logic [3:0] WIN    = 4'(WIN_SCORE);

    logic       frame_tick;
    state_t     state, state_next;
    logic [7:0] frame_cnt, cnt_next;
    logic [3:0] score1_q, score2_q, s1_next, s2_next;
    logic       cf_q, fz_q, cf_next, fz_next;
    logic [1:0] win_q, win_next;

    frame_tick_gen u_tick (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            frame_cnt <= 8'd0;
            score1_q  <= 4'd0;
            score2_q  <= 4'd0;
            cf_q      <= 1'b1;
            fz_q      <= 1'b1;
            win_q     <= WIN_NONE;
        end else begin
            state     <= state_next;
            frame_cnt <= cnt_next;
            score1_q  <= s1_next;
            score2_q  <= s2_next;
            cf_q      <= cf_next;
            fz_q      <= fz_next;
            win_q     <= win_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = frame_cnt;
        s1_next    = score1_q;
        s2_next    = score2_q;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_KICKOFF;
            end
            ST_KICKOFF: begin
                if (frame_tick) begin
                    cnt_next = frame_cnt + 8'd1;
                    if (cnt_next == KO_LIM) state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A simultaneous goal in both nets is treated as a glitch.
                if (goal1 && !goal2) begin
                    s1_next    = sat_inc(score1_q, WIN);
                    state_next = ST_GOAL;
                end else if (goal2 && !goal1) begin
                    s2_next    = sat_inc(score2_q, WIN);
                    state_next = ST_GOAL;
                end
            end
            ST_GOAL: begin
                if (frame_tick) begin
                    cnt_next = frame_cnt + 8'd1;
                    if (cnt_next == GH_LIM)
                        state_next = ((score1_q == WIN) || (score2_q == WIN)) ? ST_OVER : ST_KICKOFF;
                end
            end
            ST_OVER: begin
                if (start) begin
                    s1_next    = 4'd0;
                    s2_next    = 4'd0;
                    state_next = ST_KICKOFF;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (state_next != state) cnt_next = 8'd0;

        // Outputs are decoded from the next state so they register in step with it.
        cf_next  = (state_next == ST_IDLE) || (state_next == ST_KICKOFF);
        fz_next  = (state_next != ST_PLAY);
        win_next = WIN_NONE;
        if (state_next == ST_OVER) begin
            if (s1_next == WIN)      win_next = WIN_P1;
            else if (s2_next == WIN) win_next = WIN_P2;
        end
    end

    assign center_field = cf_q;
    assign freeze       = fz_q;
    assign score1       = score1_q;
    assign score2       = score2_q;
    assign winner       = win_q;
    assign state_o      = state;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: a goal-sequence vector table plus hand-written
// sequences for reset, start handling and the frame edge detector.
module tb_match_controller;
    import haxball_pkg::*;

    localparam int KO = 60;
    localparam int GH = 120;

    logic       Clk, Reset_n, frame_clk, start, goal1, goal2;
    logic       center_field, freeze;
    logic [3:0] score1, score2;
    logic [1:0] winner;
    logic [2:0] state_o;

    int n_vec  = 0;
    int n_fail = 0;
    logic [14:0] exp_q[$];

    match_controller #(
        .KICKOFF_FRAMES(KO), .GOAL_HOLD_FRAMES(GH), .WIN_SCORE(5)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start),
        .goal1(goal1), .goal2(goal2), .center_field(center_field), .freeze(freeze),
        .score1(score1), .score2(score2), .winner(winner), .state_o(state_o)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       g1;
        logic       g2;
        int         hold;
        state_t     st_hold;
        logic [3:0] s1;
        logic [3:0] s2;
        state_t     st_after;
        logic [1:0] w_after;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [14:0] mk(input state_t st, input logic [3:0] s1,
                                       input logic [3:0] s2, input logic [1:0] w);
        logic cf, fz;
        cf = (st == ST_IDLE) || (st == ST_KICKOFF);
        fz = (st != ST_PLAY);
        return {st, cf, fz, s1, s2, w};
    endfunction

    // driver tasks
    task automatic frames(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            repeat (3) @(negedge Clk);
            frame_clk = 1'b0;
            repeat (3) @(negedge Clk);
        end
    endtask

    task automatic pulse_start(input int cycles);
        start = 1'b1;
        repeat (cycles) @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic drive_goals(input logic g1, input logic g2, input int cycles);
        goal1 = g1;
        goal2 = g2;
        repeat (cycles) @(negedge Clk);
        goal1 = 1'b0;
        goal2 = 1'b0;
    endtask

    // scoreboard
    task automatic check(input string name);
        logic [14:0] act, exp;
        act = {state_o, center_field, freeze, score1, score2, winner};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected value queued", name);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got st=%0d cf=%0b fz=%0b s1=%0d s2=%0d w=%0d, want st=%0d cf=%0b fz=%0b s1=%0d s2=%0d w=%0d",
                         name, act[14:12], act[11], act[10], act[9:6], act[5:2], act[1:0],
                         exp[14:12], exp[11], exp[10], exp[9:6], exp[5:2], exp[1:0]);
            end
        end
    endtask

    initial begin
        int ticks;
        vecs[0] = '{1'b1, 1'b0, 500, ST_GOAL, 4'd1, 4'd0, ST_KICKOFF, WIN_NONE};
        vecs[1] = '{1'b1, 1'b1, 10,  ST_PLAY, 4'd1, 4'd0, ST_PLAY,    WIN_NONE};
        vecs[2] = '{1'b0, 1'b0, 20,  ST_PLAY, 4'd1, 4'd0, ST_PLAY,    WIN_NONE};
        vecs[3] = '{1'b0, 1'b1, 3,   ST_GOAL, 4'd1, 4'd1, ST_KICKOFF, WIN_NONE};
        vecs[4] = '{1'b0, 1'b1, 200, ST_GOAL, 4'd1, 4'd2, ST_KICKOFF, WIN_NONE};
        vecs[5] = '{1'b0, 1'b1, 1,   ST_GOAL, 4'd1, 4'd3, ST_KICKOFF, WIN_NONE};
        vecs[6] = '{1'b0, 1'b1, 50,  ST_GOAL, 4'd1, 4'd4, ST_KICKOFF, WIN_NONE};
        vecs[7] = '{1'b0, 1'b1, 7,   ST_GOAL, 4'd1, 4'd5, ST_OVER,    WIN_P2};

        Reset_n = 1'b0; frame_clk = 1'b0; start = 1'b0; goal1 = 1'b0; goal2 = 1'b0;
        repeat (3) @(negedge Clk);
        exp_q.push_back(mk(ST_IDLE, 0, 0, WIN_NONE));
        check("reset_values");
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        exp_q.push_back(mk(ST_IDLE, 0, 0, WIN_NONE));
        check("idle_after_reset");

        pulse_start(1);
        exp_q.push_back(mk(ST_KICKOFF, 0, 0, WIN_NONE));
        check("start_to_kickoff");
        frames(KO - 1);
        exp_q.push_back(mk(ST_KICKOFF, 0, 0, WIN_NONE));
        check("kickoff_minus_one");
        frames(1);
        exp_q.push_back(mk(ST_PLAY, 0, 0, WIN_NONE));
        check("kickoff_to_play");

        for (int i = 0; i < 8; i++) begin
            drive_goals(vecs[i].g1, vecs[i].g2, vecs[i].hold);
            exp_q.push_back(mk(vecs[i].st_hold, vecs[i].s1, vecs[i].s2, WIN_NONE));
            check($sformatf("vec%0d_goal", i));
            if (vecs[i].st_hold == ST_GOAL) begin
                frames(GH - 1);
                exp_q.push_back(mk(ST_GOAL, vecs[i].s1, vecs[i].s2, WIN_NONE));
                check($sformatf("vec%0d_hold_minus_one", i));
                frames(1);
                exp_q.push_back(mk(vecs[i].st_after, vecs[i].s1, vecs[i].s2, vecs[i].w_after));
                check($sformatf("vec%0d_hold_end", i));
                if (vecs[i].st_after == ST_KICKOFF) begin
                    frames(KO);
                    exp_q.push_back(mk(ST_PLAY, vecs[i].s1, vecs[i].s2, WIN_NONE));
                    check($sformatf("vec%0d_replay", i));
                end
            end
        end

        drive_goals(1'b1, 1'b0, 10);
        exp_q.push_back(mk(ST_OVER, 1, 5, WIN_P2));
        check("goal_ignored_in_over");
        pulse_start(1);
        exp_q.push_back(mk(ST_KICKOFF, 0, 0, WIN_NONE));
        check("restart_clears");
        pulse_start(5);
        frames(KO - 1);
        exp_q.push_back(mk(ST_KICKOFF, 0, 0, WIN_NONE));
        check("start_ignored_kickoff");
        frames(1);
        exp_q.push_back(mk(ST_PLAY, 0, 0, WIN_NONE));
        check("second_play");
        drive_goals(1'b1, 1'b0, 1);
        exp_q.push_back(mk(ST_GOAL, 1, 0, WIN_NONE));
        check("single_cycle_goal");
        frames(10);

        #2 Reset_n = 1'b0;
        #1;
        exp_q.push_back(mk(ST_IDLE, 0, 0, WIN_NONE));
        check("async_reset_mid_goal");
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        exp_q.push_back(mk(ST_IDLE, 0, 0, WIN_NONE));
        check("idle_after_async_reset");

        pulse_start(1);
        ticks = 0;
        frame_clk = 1'b1;
        repeat (1000) begin
            @(negedge Clk);
            if (dut.u_tick.frame_tick) ticks++;
        end
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        n_vec++;
        if (ticks != 1) begin
            n_fail++;
            $display("FAIL long_frame_tick: got %0d ticks, want 1", ticks);
        end
        frames(KO - 2);
        exp_q.push_back(mk(ST_KICKOFF, 0, 0, WIN_NONE));
        check("long_pulse_counted_once");
        frames(1);
        exp_q.push_back(mk(ST_PLAY, 0, 0, WIN_NONE));
        check("long_pulse_play");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
